// File: rtl/jb_intr_aggr.sv
// jb_intr_aggr -- interrupt aggregator and sequencer.
// Each source is synchronized, edge-detected and latched into sticky status.
// Sticky status clears on write-1. Enabled sticky bits feed a fixed-priority
// IRQ sequencer with acknowledge and holdoff.
// Parameter constraints: 2 <= N_SRC <= 64, ID_W >= clog2(N_SRC),
// 0 <= HOLDOFF_CYC <= 65535.
module jb_intr_aggr #(
  parameter int N_SRC       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_CYC = 64,
  parameter int ID_W        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src_in,
  input  logic [N_SRC-1:0]  src_mask,
  input  logic [N_SRC-1:0]  sts_clr,
  input  logic              irq_ack,
  output logic [N_SRC-1:0]  sts_sticky,
  output logic [N_SRC-1:0]  sts_raw,
  output logic              irq,
  output logic [ID_W-1:0]   irq_id,
  output logic              irq_valid_id,
  output logic [15:0]       evt_cnt
);

  // The arm counter must count to SYNC_STAGES+1 clocks.
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam int POP_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_HOLDOFF
  } state_t;

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [POP_W-1:0] rise_pop;
  logic [16:0]      evt_sum;
  logic [15:0]      evt_next;
  logic [ID_W-1:0]  prio_id;

  state_t           state_q, state_d;
  logic             irq_d;
  logic             valid_d;
  logic [ID_W-1:0]  id_d;
  logic [15:0]      hold_q, hold_d;

  // Synchronizer chain; a depth of 0 passes src_in straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sts_raw = src_in;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_q [SYNC_STAGES];

      // Shift the raw sources through SYNC_STAGES flops.
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
          sync_q[0] <= src_in;
          for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
      end

      assign sts_raw = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Hold off edge detection until the synchronizer and edge register both
  // reflect post-reset input. Levels already high at reset release are
  // treated as steady state, not as events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                arm_cnt <= '0;
    else if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + 1'b1;
  end

  assign armed = (arm_cnt == ARM_DONE);
  assign rise  = sts_raw & ~prev_q & {N_SRC{armed}};
  assign pend  = sts_sticky & src_mask;

  // Edge register, sticky status (set beats clear), and event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      sts_sticky <= '0;
      evt_cnt    <= '0;
    end else begin
      prev_q     <= sts_raw;
      sts_sticky <= (sts_sticky & ~sts_clr) | rise;
      evt_cnt    <= evt_next;
    end
  end

  // Saturating event-count update from the number of rising edges.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rise_pop = '0;
    for (int i = 0; i < N_SRC; i++) rise_pop = rise_pop + POP_W'(rise[i]);
    evt_sum  = {1'b0, evt_cnt} + 17'(rise_pop);
    evt_next = evt_sum[16] ? 16'hFFFF : evt_sum[15:0];
  end

  // Fixed priority: scanning downward leaves the lowest pending index.
  always_comb begin
    prio_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pend[i]) prio_id = ID_W'(i);
    end
  end

  // Sequencer state and registered IRQ outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      irq          <= 1'b0;
      irq_valid_id <= 1'b0;
      irq_id       <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      irq          <= irq_d;
      irq_valid_id <= valid_d;
      irq_id       <= id_d;
      hold_q       <= hold_d;
    end
  end

  // Next-state and next-output logic for the IRQ sequencer.
  always_comb begin
    state_d = state_q;
    irq_d   = irq;
    valid_d = irq_valid_id;
    id_d    = irq_id;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        irq_d   = 1'b1;
        valid_d = 1'b1;
        id_d    = prio_id;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (irq_ack) begin
          irq_d   = 1'b0;
          hold_d  = 16'(HOLDOFF_CYC);
          state_d = ST_HOLDOFF;
        end else if (pend == '0) begin
          // Cause withdrawn by clear or mask: retire without holdoff.
          irq_d   = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        // The final decrement coincides with leaving, so the ack-to-IRQ
        // gap is HOLDOFF_CYC plus the two-clock IDLE->ASSERT->irq path.
        if (hold_q <= 16'd1) begin
          hold_d  = '0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jb_intr_aggr.sv
// Directed bench for jb_intr_aggr with default parameters:
// N_SRC=32, SYNC_STAGES=2, HOLDOFF_CYC=64, ID_W=6.
module tb_jb_intr_aggr;

  logic        clk;
  logic        rst_n;
  logic [31:0] src_in;
  logic [31:0] src_mask;
  logic [31:0] sts_clr;
  logic        irq_ack;
  logic [31:0] sts_sticky;
  logic [31:0] sts_raw;
  logic        irq;
  logic [5:0]  irq_id;
  logic        irq_valid_id;
  logic [15:0] evt_cnt;

  int total;
  int bad;

  jb_intr_aggr #(
    .N_SRC(32), .SYNC_STAGES(2), .HOLDOFF_CYC(64), .ID_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .src_mask(src_mask),
    .sts_clr(sts_clr), .irq_ack(irq_ack), .sts_sticky(sts_sticky),
    .sts_raw(sts_raw), .irq(irq), .irq_id(irq_id),
    .irq_valid_id(irq_valid_id), .evt_cnt(evt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    src_in   = '1;
    src_mask = '0;
    sts_clr  = '0;
    irq_ack  = 1'b0;

    // 1. Reset, no spurious edge on release, then a single source event.
    #22;
    check("rst_irq",    irq, 0);
    check("rst_sticky", sts_sticky, 0);
    check("rst_evt",    evt_cnt, 0);
    check("rst_raw",    sts_raw, 0);
    tick();
    rst_n = 1'b1;
    tick(6);
    check("rel_sticky", sts_sticky, 0);
    check("rel_evt",    evt_cnt, 0);
    check("rel_irq",    irq, 0);
    check("rel_raw",    sts_raw, 32'hFFFF_FFFF);
    src_in = '0;
    tick(4);
    check("fall_evt", evt_cnt, 0);
    src_mask = 32'h0000_0008;
    src_in   = 32'h0000_0008;
    tick(2);
    check("s3_lat2", sts_sticky, 0);
    tick();
    check("s3_lat3", sts_sticky, 32'h8);
    check("s3_evt",  evt_cnt, 1);
    tick();
    check("s3_irq_early", irq, 0);
    tick();
    check("s3_irq",   irq, 1);
    check("s3_id",    irq_id, 3);
    check("s3_valid", irq_valid_id, 1);

    // Clearing the only pending bit in WAIT_ACK retires without holdoff.
    sts_clr = 32'h8;
    tick();
    sts_clr = '0;
    check("clr3_sticky", sts_sticky, 0);
    check("clr3_irq_hold", irq, 1);
    tick();
    check("clr3_irq",   irq, 0);
    check("clr3_valid", irq_valid_id, 0);

    // 2. Simultaneous sources 7 and 2; later source 0 must not steal the ID.
    src_mask = '1;
    src_in   = 32'h0000_008C;
    tick(3);
    check("p_sticky", sts_sticky, 32'h84);
    check("p_evt",    evt_cnt, 3);
    tick(2);
    check("p_irq", irq, 1);
    check("p_id",  irq_id, 2);
    src_in = 32'h0000_008D;
    tick(5);
    check("p_sticky0", sts_sticky, 32'h85);
    check("p_id_hold", irq_id, 2);
    check("p_irq_hold", irq, 1);
    check("p_evt4",    evt_cnt, 4);

    // 3. Ack with pend still set: irq low after T, high again at T+66.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ho_irq_t1",   irq, 0);
    check("ho_valid_t1", irq_valid_id, 1);
    tick(63);
    check("ho_valid_t64", irq_valid_id, 1);
    check("ho_irq_t64",   irq, 0);
    tick();
    check("ho_valid_exit", irq_valid_id, 0);
    tick();
    check("ho_irq_t66", irq, 0);
    tick();
    check("ho_irq_t67", irq, 1);
    check("ho_id0",     irq_id, 0);
    check("ho_valid",   irq_valid_id, 1);

    // Ack, clear everything during holdoff, and stay quiet afterwards.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    sts_clr = '1;
    tick();
    sts_clr = '0;
    tick(70);
    check("quiet_irq",    irq, 0);
    check("quiet_valid",  irq_valid_id, 0);
    check("quiet_sticky", sts_sticky, 0);

    // 4. Set beats clear on the same cycle; a lone clear then clears.
    src_mask = '0;
    src_in   = 32'h0000_00AD;
    tick(2);
    sts_clr = 32'h20;
    tick();
    sts_clr = '0;
    check("coll_sticky", sts_sticky, 32'h20);
    sts_clr = 32'h20;
    tick();
    sts_clr = '0;
    check("lone_clr", sts_sticky, 0);
    check("coll_evt", evt_cnt, 5);

    // 5. Masked source latches but stays silent; unmask raises IRQ.
    src_in = 32'h0000_00BD;
    tick(3);
    check("m_sticky", sts_sticky, 32'h10);
    tick(4);
    check("m_irq_off", irq, 0);
    src_mask = 32'h10;
    tick(2);
    check("m_irq", irq, 1);
    check("m_id",  irq_id, 4);
    // Masking the cause in WAIT_ACK retires it like a clear.
    src_mask = '0;
    tick();
    check("m_unmask_irq",   irq, 0);
    check("m_unmask_valid", irq_valid_id, 0);
    // Ack while in IDLE/ASSERT is ignored.
    src_mask = 32'h10;
    irq_ack  = 1'b1;
    tick(2);
    irq_ack = 1'b0;
    check("ack_ignored", irq, 1);
    sts_clr = 32'h10;
    tick();
    sts_clr = '0;
    tick();
    check("m_clr_irq", irq, 0);
    src_mask = '0;
    check("m_evt", evt_cnt, 6);

    // 6. Drive the event counter into saturation.
    src_in = '0;
    tick(4);
    for (int i = 0; i < 2047; i++) begin
      src_in = '1;
      tick();
      src_in = '0;
      tick();
    end
    tick(4);
    check("sat_pre", evt_cnt, 16'hFFE6);
    src_in = 32'h00FF_FFFF;
    tick(4);
    check("sat_fffe", evt_cnt, 16'hFFFE);
    src_in = 32'h07FF_FFFF;
    tick(4);
    check("sat_ffff", evt_cnt, 16'hFFFF);

    // Asynchronous reset in WAIT_ACK, observed between clock edges.
    src_mask = '1;
    tick(3);
    check("ar_irq_pre", irq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_irq",    irq, 0);
    check("ar_valid",  irq_valid_id, 0);
    check("ar_sticky", sts_sticky, 0);
    check("ar_evt",    evt_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick(6);
    check("ar_rel_evt",    evt_cnt, 0);
    check("ar_rel_sticky", sts_sticky, 0);
    check("ar_rel_irq",    irq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jb_intr_aggr.md
Name: jb_intr_aggr

Overview:
Interrupt aggregator and sequencer for the alarm/error sources carried on the interrupt-control interface (framing errors, ADC thresholds, external alarms, SFP status, RF overdrive/slew).
- Synchronizes and edge-detects each source, then holds it in a sticky status register with mask and write-1-to-clear.
- Drives one host IRQ line through an assert/acknowledge/holdoff state machine, reporting the highest-priority pending source ID.
- Sits between the source producers and the register map.

Parameters:
N_SRC, 32, number of interrupt sources; must be 2 to 64.
SYNC_STAGES, 2, synchronizer depth on src_in; 0 means inputs are already in the clk domain.
HOLDOFF_CYC, 64, minimum clocks between acknowledge and the next IRQ assertion; 0 to 65535.
ID_W, 6, width of the source index; ID_W must be at least clog2(N_SRC).

Ports:
clk  in  1  block clock
rst_n  in  1  asynchronous active-low reset
src_in  in  N_SRC  raw level sources, active high
src_mask  in  N_SRC  1 = source enabled to raise IRQ
sts_clr  in  N_SRC  write-1-to-clear strobe for sticky status, one cycle
irq_ack  in  1  host acknowledge pulse
sts_sticky  out  N_SRC  latched rising-edge status
sts_raw  out  N_SRC  synchronized live level
irq  out  1  level interrupt to host
irq_id  out  ID_W  index of the source that caused the current IRQ
irq_valid_id  out  1  irq_id is meaningful
evt_cnt  out  16  total latched events, saturating

Behaviour:
- Reset: clk and rst_n as stated; reset is asynchronous and active-low. All outputs, synchronizer flops, edge registers, the FSM and counters clear to 0 immediately on rst_n low. Deasserting reset does not produce a spurious edge: the edge register reloads from the synchronized value on the first clock after reset.
- Synchronization: sts_raw is src_in delayed SYNC_STAGES clocks.
- Edge detect: rise[i] = sts_raw[i] & ~prev[i], where prev is sts_raw delayed by 1 clock.
- Sticky: sts_sticky[i] sets on rise[i] and clears on sts_clr[i]. When both occur in the same cycle, set wins. Latency from src_in edge to sticky is SYNC_STAGES+1 clocks. Masking does not block the sticky latch.
- Pending: pend = sts_sticky & src_mask. Priority is fixed: lowest index wins.
- evt_cnt: increments by popcount(rise) each clock and saturates at 0xFFFF. Only host reset clears it.
- FSM:
  - IDLE: when pend != 0, go to ASSERT.
  - ASSERT (1 clock): latch irq_id = priority index of pend, set irq and irq_valid_id, go to WAIT_ACK.
  - WAIT_ACK: irq held high.
    - On irq_ack: drop irq, load the holdoff counter with HOLDOFF_CYC, go to HOLDOFF. irq_valid_id stays high until HOLDOFF exits.
    - If pend becomes 0 before the ack (host cleared status), drop irq and irq_valid_id and return to IDLE without holdoff.
  - HOLDOFF: count down to 0, then clear irq_valid_id and go to IDLE. If HOLDOFF_CYC=0, return to IDLE on the next clock.
- IRQ timing: from IDLE with pend != 0, irq rises 2 clocks later (IDLE→ASSERT, then registered output). irq_id is stable while irq is high and does not change if higher-priority sources arrive meanwhile.
- irq_ack outside WAIT_ACK is ignored.
- A mask change that removes the pending cause while in WAIT_ACK is handled the same as clear: go to IDLE.
- A mask change that unmasks an already-sticky bit raises an IRQ from IDLE as normal.

Test Plan:
1. Reset and edge: rst_n low with src_in=all ones, then release → sts_sticky stays 0, irq=0, evt_cnt=0. Next, a 0→1 on src 3 with mask[3]=1 → sts_sticky[3]=1 after 3 clocks, irq high 2 clocks later, irq_id=3, evt_cnt=1.
2. Priority and hold: sources 7 and 2 rise in the same cycle, then src 0 rises during WAIT_ACK → irq_id=2 and stays 2; after ack and holdoff, next IRQ has irq_id=0.
3. Holdoff timing with HOLDOFF_CYC=64: irq_ack at cycle T with pend still nonzero → irq low at T+1 and high again at T+66, not earlier.
4. Clear vs set collision: sts_clr[5] asserted in the same cycle as a rise on src 5 → sts_sticky[5]=1. A lone sts_clr[5] clears it. Clearing the only pending bit during WAIT_ACK → irq drops next clock and FSM returns to IDLE without holdoff.
5. Mask behaviour: mask[4]=0 and src 4 rises → sticky[4]=1 and irq stays 0. Setting mask[4]=1 → irq asserts with irq_id=4.
6. Saturation and reset mid-operation: force 0xFFFF events then 3 more → evt_cnt=0xFFFF. Assert rst_n during WAIT_ACK → irq, irq_valid_id, sticky and evt_cnt go to 0 asynchronously, without waiting for a clock edge.
